// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register carrying PC/instruction/side-band between stages, 1-cycle latency.
// Valid/ready handshake; SKID=1 adds a second entry so in_ready is registered, flush injects a NOP bubble.
module pipe_stage_reg #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter int                SIDE_W   = 8,
   parameter int                SKID     = 1,
   parameter logic [31:0]       NOP_INST = 32'h00000013,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic                clk_PR,
   input  logic                rst_n_PR,
   input  logic                flush_PR,
   input  logic                in_valid_PR,
   output logic                in_ready_PR,
   input  logic [PC_W-1:0]     in_pc_PR,
   input  logic [INST_W-1:0]   in_inst_PR,
   input  logic [SIDE_W-1:0]   in_side_PR,
   output logic                out_valid_PR,
   input  logic                out_ready_PR,
   output logic [PC_W-1:0]     out_pc_PR,
   output logic [INST_W-1:0]   out_inst_PR,
   output logic [SIDE_W-1:0]   out_side_PR,
   output logic                out_bubble_PR,
   output logic [1:0]          occ_PR,
   output logic [CNT_W-1:0]    bubble_cnt_PR
);

   localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

   logic                s_valid, s_valid_n;
   logic [PC_W-1:0]     s_pc, s_pc_n;
   logic [INST_W-1:0]   s_inst, s_inst_n;
   logic [SIDE_W-1:0]   s_side, s_side_n;

   logic                m_valid_n, m_bubble_n;
   logic [PC_W-1:0]     m_pc_n;
   logic [INST_W-1:0]   m_inst_n;
   logic [SIDE_W-1:0]   m_side_n;

   logic                rdy_q;
   logic                in_fire, out_fire;
   logic [1:0]          occ_n;
   logic [CNT_W-1:0]    cnt_n;

   assign in_ready_PR = (SKID != 0) ? rdy_q : (!out_valid_PR | out_ready_PR);
   assign in_fire     = in_valid_PR & in_ready_PR;
   assign out_fire    = out_valid_PR & out_ready_PR;

   always_comb begin
      m_valid_n  = out_valid_PR;
      m_pc_n     = out_pc_PR;
      m_inst_n   = out_inst_PR;
      m_side_n   = out_side_PR;
      m_bubble_n = out_bubble_PR;
      s_valid_n  = s_valid;
      s_pc_n     = s_pc;
      s_inst_n   = s_inst;
      s_side_n   = s_side;

      if (flush_PR) begin
         // flush overrides every handshake in this cycle
         m_valid_n  = 1'b1;
         m_pc_n     = RESET_PC;
         m_inst_n   = NOP;
         m_side_n   = '0;
         m_bubble_n = 1'b1;
         s_valid_n  = 1'b0;
      end else if (!out_valid_PR || out_fire) begin
         if (s_valid) begin
            m_valid_n  = 1'b1;
            m_pc_n     = s_pc;
            m_inst_n   = s_inst;
            m_side_n   = s_side;
            m_bubble_n = 1'b0;
            s_valid_n  = 1'b0;
         end else if (in_fire) begin
            m_valid_n  = 1'b1;
            m_pc_n     = in_pc_PR;
            m_inst_n   = in_inst_PR;
            m_side_n   = in_side_PR;
            m_bubble_n = 1'b0;
         end else begin
            m_valid_n  = 1'b0;
            m_bubble_n = 1'b0;
         end
      end else if (in_fire && (SKID != 0)) begin
         // main entry stalled: park the new beat in the skid entry
         s_valid_n = 1'b1;
         s_pc_n    = in_pc_PR;
         s_inst_n  = in_inst_PR;
         s_side_n  = in_side_PR;
      end

      occ_n = {1'b0, m_valid_n} + {1'b0, s_valid_n};
      cnt_n = (flush_PR && (bubble_cnt_PR != '1)) ? bubble_cnt_PR + CNT_W'(1) : bubble_cnt_PR;
   end

   always_ff @(posedge clk_PR or negedge rst_n_PR) begin
      if (!rst_n_PR) begin
         out_valid_PR  <= 1'b0;
         out_pc_PR     <= RESET_PC;
         out_inst_PR   <= NOP;
         out_side_PR   <= '0;
         out_bubble_PR <= 1'b0;
         s_valid       <= 1'b0;
         s_pc          <= '0;
         s_inst        <= '0;
         s_side        <= '0;
         occ_PR        <= 2'd0;
         bubble_cnt_PR <= '0;
         rdy_q         <= 1'b1;
      end else begin
         out_valid_PR  <= m_valid_n;
         out_pc_PR     <= m_pc_n;
         out_inst_PR   <= m_inst_n;
         out_side_PR   <= m_side_n;
         out_bubble_PR <= m_bubble_n;
         s_valid       <= s_valid_n;
         s_pc          <= s_pc_n;
         s_inst        <= s_inst_n;
         s_side        <= s_side_n;
         occ_PR        <= occ_n;
         bubble_cnt_PR <= cnt_n;
         rdy_q         <= !s_valid_n;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (SKID=1, CNT_W=2): queue-based reference model with a scoreboard monitor.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [7:0]  side;
      logic        bubble;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic [7:0]  in_side = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [7:0]  out_side;
   logic        out_bubble;
   logic [1:0]  occ;
   logic [1:0]  bubble_cnt;

   int checks = 0;
   int errors = 0;
   int nflush = 0;
   beat_t q[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.PC_W(32), .INST_W(32), .SIDE_W(8), .SKID(1),
                    .NOP_INST(32'h00000013), .RESET_PC(32'h0), .CNT_W(2)) dut (
      .clk_PR(clk), .rst_n_PR(rst_n), .flush_PR(flush),
      .in_valid_PR(in_valid), .in_ready_PR(in_ready),
      .in_pc_PR(in_pc), .in_inst_PR(in_inst), .in_side_PR(in_side),
      .out_valid_PR(out_valid), .out_ready_PR(out_ready),
      .out_pc_PR(out_pc), .out_inst_PR(out_inst), .out_side_PR(out_side),
      .out_bubble_PR(out_bubble), .occ_PR(occ), .bubble_cnt_PR(bubble_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: the head of the queue must be on the outputs whenever out_valid is high.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat: out_valid with no beat expected at %0t", $time);
         end else begin
            chk("beat", {out_pc, out_inst, out_side, out_bubble}, q[0]);
            if (out_ready && !flush) void'(q.pop_front());
         end
      end
   end

   // One clock cycle: check model-derived status, drive inputs, then update the model.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [7:0] side, input logic ordy, input logic fl);
      int n;
      beat_t b;
      @(posedge clk);
      #1;
      n = q.size();
      chk("occ", occ, n);
      chk("in_ready", in_ready, n < 2);
      chk("out_valid", out_valid, n > 0);
      chk("bubble_cnt", bubble_cnt, (nflush > 3) ? 3 : nflush);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = inst;
      in_side   = side;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      #1;
      if (fl) begin
         q.delete();
         b = '{pc: 32'h0, inst: 32'h00000013, side: 8'h0, bubble: 1'b1};
         q.push_back(b);
         nflush++;
      end else if (v && n < 2) begin
         b = '{pc: pc, inst: inst, side: side, bubble: 1'b0};
         q.push_back(b);
      end
   endtask

   task automatic idle(input int cycles, input logic ordy);
      for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 32'h0, 8'h0, ordy, 1'b0);
   endtask

   initial begin
      #12;
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst out_inst", out_inst, 32'h00000013);
      chk("rst out_pc", out_pc, 32'h0);
      chk("rst occ", occ, 2'd0);
      chk("rst in_ready", in_ready, 1'b1);
      chk("rst bubble_cnt", bubble_cnt, 2'd0);
      rst_n = 1'b1;
      idle(2, 1'b1);

      // streaming at full rate
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'(i * 4), 32'h00500093 + 32'(i << 7), 8'(i), 1'b1, 1'b0);
      idle(2, 1'b1);

      // back-pressure fills the skid entry, then drains in order
      step(1'b1, 32'h10, 32'h00100113, 8'h5a, 1'b0, 1'b0);
      step(1'b1, 32'h14, 32'h00200193, 8'ha5, 1'b0, 1'b0);
      step(1'b1, 32'h18, 32'h00300213, 8'h33, 1'b0, 1'b0);
      idle(2, 1'b0);
      idle(4, 1'b1);

      // flush with a full pipe and an input offered in the same cycle
      step(1'b1, 32'h20, 32'h1, 8'h1, 1'b0, 1'b0);
      step(1'b1, 32'h24, 32'h2, 8'h2, 1'b0, 1'b0);
      step(1'b1, 32'h28, 32'h3, 8'h3, 1'b0, 1'b1);
      idle(2, 1'b0);
      idle(2, 1'b1);

      // consecutive flushes drive the 2-bit counter into saturation
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b1);
      idle(2, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3fffffff), 2'b00}, $urandom,
              8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      idle(4, 1'b1);

      // asynchronous reset between clock edges with two beats held
      step(1'b1, 32'h40, 32'h4, 8'h4, 1'b0, 1'b0);
      step(1'b1, 32'h44, 32'h5, 8'h5, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0);
      chk("pre-reset occ", occ, 2'd2);
      #1;
      rst_n = 1'b0;
      q.delete();
      nflush = 0;
      #1;
      chk("arst out_valid", out_valid, 1'b0);
      chk("arst occ", occ, 2'd0);
      chk("arst in_ready", in_ready, 1'b1);
      chk("arst out_inst", out_inst, 32'h00000013);
      chk("arst out_pc", out_pc, 32'h0);
      chk("arst out_side", out_side, 8'h0);
      chk("arst out_bubble", out_bubble, 1'b0);
      chk("arst bubble_cnt", bubble_cnt, 2'd0);
      #1;
      rst_n = 1'b1;
      idle(2, 1'b1);
      step(1'b1, 32'h80, 32'h00500093, 8'h7, 1'b1, 1'b0);
      idle(3, 1'b1);

      chk("drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
